// File: rtl/servix_rst_seq.sv
// servix_rst_seq: reset sequencer between the servix clock generator and the
// SERV core. The system reset asserts asynchronously on i_rst and releases
// synchronously after a synchronizer delay plus a programmable stretch.
// Optional debounced push-button reset, built when SERVIX_RST_BTN_EN is defined.
module servix_rst_seq #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STRETCH     = 16,
    parameter int unsigned DEBOUNCE    = 1024
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn,
    output logic       o_rst,
    output logic       o_ready,
    output logic [7:0] o_btn_cnt
);

    // The FSM state register acts as the final synchronizer stage, so the
    // explicit chain holds SYNC_STAGES-1 flops.
    localparam int unsigned CHAIN_W = SYNC_STAGES - 1;
    localparam int unsigned CNT_W   = (STRETCH > 1) ? $clog2(STRETCH) : 1;
    localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH - 1);

    typedef enum logic [1:0] {
        StSync,
        StStretch,
        StRun,
        StHold
    } state_t;

    logic [CHAIN_W-1:0] r_sync;
    logic               w_sync_out;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_rst;
    logic               r_ready;
    logic               w_btn_db;
    logic               w_btn_accept;

    assign w_sync_out = r_sync[CHAIN_W-1];

    // Reset-release synchronizer: set on i_rst, shifts in zeros afterwards.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= r_sync << 1;
        end
    end

`ifdef SERVIX_RST_BTN_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    logic [1:0]      r_bsync;
    logic            r_db;
    logic [DB_W-1:0] r_db_cnt;
    logic [7:0]      r_btn_cnt;

    // Button synchronizer and debouncer; any agreement restarts the count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bsync  <= 2'b00;
            r_db     <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_bsync <= {r_bsync[0], i_btn};
            if (r_bsync[1] != r_db) begin
                if (r_db_cnt == DB_LAST) begin
                    r_db     <= r_bsync[1];
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DB_W'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // Saturating count of button resets accepted from RUN.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_btn_cnt <= 8'd0;
        end else if (w_btn_accept && (r_btn_cnt != 8'hff)) begin
            r_btn_cnt <= r_btn_cnt + 8'd1;
        end
    end

    assign w_btn_db  = r_db;
    assign o_btn_cnt = r_btn_cnt;
`else
    logic w_btn_unused;

    assign w_btn_unused = i_btn;
    assign w_btn_db     = 1'b0;
    assign o_btn_cnt    = 8'd0;
`endif

    assign w_btn_accept = (r_state == StRun) && w_btn_db;

    // FSM state, stretch counter and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StSync;
            r_cnt   <= '0;
            r_rst   <= 1'b1;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rst   <= (w_state_nxt != StRun);
            r_ready <= (w_state_nxt == StRun);
        end
    end

    // Next-state logic: stretch after sync release or after button release.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            StSync: begin
                if (!w_sync_out) begin
                    w_cnt_nxt   = STRETCH_LOAD;
                    w_state_nxt = StStretch;
                end
            end
            StStretch: begin
                if (r_cnt == '0) begin
                    w_state_nxt = StRun;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            StRun: begin
                if (w_btn_db) begin
                    w_state_nxt = StHold;
                end
            end
            StHold: begin
                if (!w_btn_db) begin
                    w_cnt_nxt   = STRETCH_LOAD;
                    w_state_nxt = StStretch;
                end
            end
            default: begin
                w_state_nxt = StSync;
            end
        endcase
    end

    assign o_rst   = r_rst;
    assign o_ready = r_ready;

endmodule

// File: doc/servix_rst_seq.md
# servix_rst_seq

Reset sequencer between the servix clock generator and the SERV core/servant SoC. Takes the generator's PLL-derived reset, asserts the system reset asynchronously, and releases it synchronously after a synchronizer delay plus a programmable stretch. Optionally adds a debounced push-button reset.

## Interface

Parameters:
- SYNC_STAGES, 2: flops in the reset-release synchronizer; legal values 2–4.
- STRETCH, 16: cycles o_rst is held after synchronized release; legal values 1–65535.
- DEBOUNCE, 1024: consecutive stable cycles required to accept a button level change; legal values 2–65535.

Ports:
- i_clk  in  1  system clock (PLL output of the clock generator)
- i_rst  in  1  reset from the clock generator; asynchronous, active-high
- i_btn  in  1  raw push-button, active-high, asynchronous to i_clk
- o_rst  out 1  system reset to core, active-high
- o_ready  out 1  high once the sequence has completed and the system is running
- o_btn_cnt  out 8  number of accepted button resets, saturating

## Operation

- Clock and reset: one clock, i_clk. Reset is asynchronous and active-high on i_rst.
- i_rst=1 sets the following immediately, without waiting for a clock edge:
  - o_rst=1, o_ready=0, o_btn_cnt=0
  - synchronizer chain set to all ones, stretch counter=0, debounce state cleared, FSM=SYNC
- FSM states:
  - SYNC: o_rst=1. When the synchronizer output goes low, load the counter with STRETCH-1 and go to STRETCH.
  - STRETCH: o_rst=1. Decrement the counter each cycle. At 0, go to RUN.
  - RUN: o_rst=0, o_ready=1. On a debounced button rising edge, go to HOLD and increment o_btn_cnt (saturate at 255).
  - HOLD: o_rst=1, o_ready=0. Stay while the debounced button is high. On the debounced falling edge, load STRETCH-1 and go to STRETCH.
- o_rst and o_ready are registered outputs of the FSM; there is no combinational path from i_btn.
- Button path: a 2-flop synchronizer feeds the debouncer. The debounced level changes only after the synchronized input has differed from it for DEBOUNCE consecutive cycles. Any glitch restarts the count.
- Counters are sized to $clog2 of their parameter. Wrap-around is impossible by construction.
- Button activity during SYNC or STRETCH is tracked by the debouncer but starts no new sequence. If the debounced level is high on entry to RUN, the FSM goes to HOLD on the next cycle and counts it.
- i_rst asserted mid-sequence (any state): immediate abort to the reset values listed above.

## Timing

- Reset assertion: o_rst rises asynchronously on i_rst rising, with zero clock latency.
- Reset release: i_rst low before rising edge E0. o_rst falls after edge E0+SYNC_STAGES+STRETCH; o_ready rises at the same edge. With defaults, o_rst is low after 18 edges.
- Button reset: the raw press, once stable, raises o_rst DEBOUNCE+3 edges after the first sampling edge. That is 2 edges of synchronizer, DEBOUNCE edges of debounce, and 1 edge of FSM register.
- Button release: o_rst falls DEBOUNCE+2+STRETCH+1 edges after the raw release.
- o_btn_cnt updates on the same edge as the RUN→HOLD transition.

## Configuration

- Macro: SERVIX_RST_BTN_EN.
- Defined: the button synchronizer, debouncer, HOLD state and o_btn_cnt logic are built. Behaviour is as described in Operation.
- Undefined: i_btn is ignored and no button logic is built. The FSM never leaves RUN except via i_rst, and o_btn_cnt is tied to 0. The port list is identical in both builds.

## Test plan

- Power-up: i_rst=1 for 5 cycles, then 0 with defaults → o_rst=1 throughout, o_rst=0 and o_ready=1 exactly 18 edges after release, o_btn_cnt=0.
- Async assert: i_rst pulsed high mid-cycle during RUN → o_rst=1 before the next edge, o_ready=0 immediately, and the full 18-edge release repeats.
- Reset mid-STRETCH: i_rst reasserted at edge 10 of the release sequence → sequence restarts; o_rst falls 18 edges after the second release.
- Button (macro defined, DEBOUNCE=8): clean press of 20 cycles from RUN → o_rst rises 11 edges after press, o_btn_cnt=1, and o_rst falls 8+2+16+1 edges after release.
- Bounce rejection (DEBOUNCE=8): i_btn toggles high for 5 cycles, low for 1, repeated 4 times → o_rst stays 0, o_btn_cnt stays 0.
- Saturation and build-out: 260 accepted presses → o_btn_cnt=255. Rebuilt without SERVIX_RST_BTN_EN, with the same stimulus → o_rst stays 0, o_btn_cnt=0.
